mdu_param: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. Holds the HI/LO pair.
- Successor to the fixed 32-bit MDU. Adds:
  - configurable width and latencies
  - MADD/MSUB accumulate ops
  - divide-by-zero flag
  - pipeline flush/abort
- The hazard controller stalls D whenever (start | busy) and an MD instruction sits in D.

---
 rtl/mdu_param.sv | 144 ++++++++++++++
 tb/tb_mdu_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// Multi-cycle multiply/divide unit for the E stage. It holds the HI/LO pair.
// MULT/MULTU/MADD/MSUB/DIV/DIVU are multi-cycle operations. MTHI/MTLO complete in a single cycle.
module mdu_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_a, r_b, r_hi, r_lo;
  logic [2:0]           r_op;
  logic                 r_div0;

  logic                 w_accept, w_multi, w_last, w_done, w_is_div, w_by_zero;
  logic [2*WIDTH-1:0]   w_prod, w_divr, w_res;

  // Low 2W bits of the product of the extended operands give the signed or unsigned product.
  function automatic logic [2*WIDTH-1:0] f_mul(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             sgn);
    logic [2*WIDTH-1:0] ex, ey;
    ex = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ey = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    return ex * ey;
  endfunction

  // The divide is done on magnitudes and the signs are applied afterwards. MIN_NEG / -1 wraps to MIN_NEG with remainder 0.
  // The result is returned as {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] f_div(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             sgn);
    logic             nx, ny;
    logic [WIDTH-1:0] mx, my, q, r;
    nx = sgn & x[WIDTH-1];
    ny = sgn & y[WIDTH-1];
    mx = nx ? (~x + ONE_W) : x;
    my = ny ? (~y + ONE_W) : y;
    q  = mx / my;
    r  = mx % my;
    if (nx ^ ny) q = ~q + ONE_W;
    if (nx)      r = ~r + ONE_W;
    return {r, q};
  endfunction

  assign w_accept  = start && !flush && (r_state == S_IDLE);
  assign w_multi   = (op != OP_MTHI) && (op != OP_MTLO);
  assign w_last    = (r_state == S_BUSY) && (r_cnt == CNT_W'(1));
  assign w_done    = w_last && !flush;
  assign w_is_div  = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_by_zero = w_is_div && (r_b == '0);

  assign w_prod = f_mul(r_a, r_b, r_op != OP_MULTU);
  assign w_divr = f_div(r_a, r_b, r_op == OP_DIV);

  always_comb begin
    w_res = w_prod;
    case (r_op)
      OP_MADD:         w_res = {r_hi, r_lo} + w_prod;
      OP_MSUB:         w_res = {r_hi, r_lo} - w_prod;
      OP_DIV, OP_DIVU: w_res = w_divr;
      default:         w_res = w_prod;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_multi) w_state_nxt = S_BUSY;
      S_BUSY:  if (flush || w_last)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_div0 <= 1'b0;
    end else begin
      r_div0 <= w_done && w_by_zero;
      if (w_accept) begin
        case (op)
          OP_MTHI: r_hi <= a;
          OP_MTLO: r_lo <= a;
          default: begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_cnt <= ((op == OP_DIV) || (op == OP_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                         : CNT_W'(MUL_CYCLES);
          end
        endcase
      end else if (r_state == S_BUSY) begin
        r_cnt <= (flush || w_last) ? '0 : r_cnt - CNT_W'(1);
      end
      // A divide by zero keeps its full latency but leaves HI/LO unchanged.
      if (w_done && !w_by_zero) {r_hi, r_lo} <= w_res;
    end
  end

  assign busy = (r_state == S_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign div0 = r_div0;

endmodule

// File: tb/tb_mdu_param.sv
// Directed bench for mdu_param. It drives a default 32-bit instance and a 16-bit instance with MUL_CYCLES=1 and DIV_CYCLES=3.
module tb_mdu_param;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO  = 3'b101, MADD = 3'b110, MSUB = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n, start32, flush32, busy32, d0_32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        rst16_n, start16, flush16, busy16, d0_16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_param u32 (
    .clk(clk), .reset(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .busy(busy32), .hi(hi32), .lo(lo32), .div0(d0_32)
  );

  mdu_param #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u16 (
    .clk(clk), .reset(rst16_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .flush(flush16), .busy(busy16), .hi(hi16), .lo(lo16), .div0(d0_16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        d0;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issues one op and waits until busy drops. It returns the number of busy cycles and the resulting outputs.
  task automatic do_op(input bit s16, input logic [2:0] o, input logic [31:0] xa,
                       input logic [31:0] xb, output int lat, output logic [31:0] rh,
                       output logic [31:0] rl, output logic d0);
    if (s16) begin start16 = 1'b1; op16 = o; a16 = xa[15:0]; b16 = xb[15:0]; end
    else     begin start32 = 1'b1; op32 = o; a32 = xa;       b32 = xb;       end
    @(posedge clk); #1;
    start16 = 1'b0;
    start32 = 1'b0;
    lat = 0;
    while ((s16 ? busy16 : busy32) && lat < 200) begin
      lat++;
      @(posedge clk); #1;
    end
    rh = s16 ? {16'h0, hi16} : hi32;
    rl = s16 ? {16'h0, lo16} : lo32;
    d0 = s16 ? d0_16 : d0_32;
  endtask

  initial begin
    int          lat;
    logic [31:0] rh, rl;
    logic        d0;

    tv[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,          32'hFFFFFFFF, 32'hFFFFFFEB, 5,  1'b0};
    tv[1]  = '{MULTU, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE, 5,  1'b0};
    tv[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0};
    tv[3]  = '{MTHI,  32'd5,        32'd0,          32'h00000005, 32'hFFFFFFFD, 0,  1'b0};
    tv[4]  = '{MTLO,  32'd6,        32'd0,          32'h00000005, 32'h00000006, 0,  1'b0};
    tv[5]  = '{DIV,   32'd1,        32'd0,          32'h00000005, 32'h00000006, 10, 1'b1};
    tv[6]  = '{DIVU,  32'd100,      32'd7,          32'h00000002, 32'h0000000E, 10, 1'b0};
    tv[7]  = '{MULT,  32'd3,        32'd4,          32'h00000000, 32'h0000000C, 5,  1'b0};
    tv[8]  = '{MADD,  32'd2,        32'd5,          32'h00000000, 32'h00000016, 5,  1'b0};
    tv[9]  = '{MSUB,  32'd30,       32'd1,          32'hFFFFFFFF, 32'hFFFFFFF8, 5,  1'b0};
    tv[10] = '{DIV,   32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, 10, 1'b0};
    tv[11] = '{DIV,   32'd7,        32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, 10, 1'b0};

    rst_n = 1'b0; rst16_n = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start16 = 1'b0; flush16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    #1;
    chk("rst_hi", hi32, 32'h0);
    chk("rst_lo", lo32, 32'h0);
    chk("rst_busy", {31'h0, busy32}, 32'h0);
    chk("rst_div0", {31'h0, d0_32}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst16_n = 1'b1;

    // Each vector is issued in the first cycle after the previous one drops busy.
    for (int i = 0; i < 12; i++) begin
      do_op(1'b0, tv[i].op, tv[i].a, tv[i].b, lat, rh, rl, d0);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_hi", i), rh, tv[i].hi);
      chk($sformatf("v%0d_lo", i), rl, tv[i].lo);
      chk($sformatf("v%0d_div0", i), {31'h0, d0}, {31'h0, tv[i].d0});
    end

    // The divide-by-zero pulse lasts exactly one cycle.
    do_op(1'b0, MTHI, 32'hA, 32'h0, lat, rh, rl, d0);
    do_op(1'b0, MTLO, 32'hB, 32'h0, lat, rh, rl, d0);
    do_op(1'b0, DIVU, 32'd3, 32'd0, lat, rh, rl, d0);
    chk("dz_lat", 32'(lat), 32'd10);
    chk("dz_pulse", {31'h0, d0}, 32'h1);
    chk("dz_hi", rh, 32'hA);
    chk("dz_lo", rl, 32'hB);
    @(posedge clk); #1;
    chk("dz_pulse_end", {31'h0, d0_32}, 32'h0);

    // Flush is raised in the 4th busy cycle of a DIVU.
    start32 = 1'b1; op32 = DIVU; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("fl_busy_before", {31'h0, busy32}, 32'h1);
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    chk("fl_busy_after", {31'h0, busy32}, 32'h0);
    repeat (12) begin @(posedge clk); #1; end
    chk("fl_hi", hi32, 32'hA);
    chk("fl_lo", lo32, 32'hB);
    chk("fl_div0", {31'h0, d0_32}, 32'h0);

    // When start and flush arrive together, the MTLO is ignored.
    start32 = 1'b1; flush32 = 1'b1; op32 = MTLO; a32 = 32'd9;
    @(posedge clk); #1;
    start32 = 1'b0; flush32 = 1'b0;
    chk("sf_lo", lo32, 32'hB);
    chk("sf_busy", {31'h0, busy32}, 32'h0);

    // A flush on the completion edge discards the result.
    start32 = 1'b1; op32 = DIVU; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("fc_busy_last", {31'h0, busy32}, 32'h1);
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    chk("fc_busy", {31'h0, busy32}, 32'h0);
    chk("fc_hi", hi32, 32'hA);
    chk("fc_lo", lo32, 32'hB);

    // Checks on the narrow instance, ending with a reset asserted in the middle of a DIV.
    do_op(1'b1, MULT, 32'h0000FFFD, 32'd7, lat, rh, rl, d0);
    chk("w16_mul_lat", 32'(lat), 32'd1);
    chk("w16_mul_hi", rh, 32'h0000FFFF);
    chk("w16_mul_lo", rl, 32'h0000FFEB);
    do_op(1'b1, DIV, 32'h00008000, 32'h0000FFFF, lat, rh, rl, d0);
    chk("w16_div_lat", 32'(lat), 32'd3);
    chk("w16_div_hi", rh, 32'h0);
    chk("w16_div_lo", rl, 32'h00008000);
    start16 = 1'b1; op16 = DIV; a16 = 16'd7; b16 = 16'd2;
    @(posedge clk); #1;
    start16 = 1'b0;
    chk("w16_rst_busy_pre", {31'h0, busy16}, 32'h1);
    rst16_n = 1'b0;
    #1;
    chk("w16_rst_busy", {31'h0, busy16}, 32'h0);
    chk("w16_rst_hi", {16'h0, hi16}, 32'h0);
    chk("w16_rst_lo", {16'h0, lo16}, 32'h0);
    chk("w16_rst_div0", {31'h0, d0_16}, 32'h0);
    @(posedge clk); #1;
    rst16_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
